img_col_buf: RTL

Raster-to-column line buffer that sits directly upstream of the NPU conv image path. It accepts a streaming 8-bit image in row-major order and emits one vertical K_H-pixel column per accepted pixel once K_H-1 rows are buffered. Each column is packed into a 32-bit word laid out exactly as the NPU image-load write (sel 3'b001) expects, so a sequencer can forward it unchanged.

---
 rtl/img_col_buf.sv | 107 ++++++++++
 1 files changed

// File: rtl/img_col_buf.sv
// Raster-to-column line buffer: emits {pad, row r, row r-1, row r-2} per accepted pixel once two rows are stored.
// Latency 1 cycle through a single output register; in_ready passes out_ready through, with no skid storage.
module img_col_buf #(
   parameter int IMG_W = 15,
   parameter int IMG_H = 16,
   parameter int K_H   = 3,
   parameter int DW    = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clear,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [31:0]   out_word,
   output logic          out_first,
   output logic          out_last,
   output logic          frame_done
);

   localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam int PAD_W = 32 - 3 * DW;

   localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_W - 1);
   localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_H - 1);
   localparam logic [ROW_W-1:0] ROW_FIRST = ROW_W'(K_H - 1);

   generate
      if (K_H != 3) begin : g_kh_check
         $error("img_col_buf: K_H must be 3 for the 32-bit column packing");
      end
      if (PAD_W < 1) begin : g_dw_check
         $error("img_col_buf: three pixels of DW bits must fit below bit 32");
      end
   endgenerate

   logic [DW-1:0]    lb0 [IMG_W];
   logic [DW-1:0]    lb1 [IMG_W];
   logic [COL_W-1:0] col_cnt;
   logic [ROW_W-1:0] row_cnt;
   logic [DW-1:0]    lb0_rd;
   logic [DW-1:0]    lb1_rd;
   logic             accept;
   logic             col_wrap;
   logic             frame_end;
   logic             emit;

   assign in_ready  = !clear && (!out_valid || out_ready);
   assign accept    = in_valid && in_ready;
   assign col_wrap  = (col_cnt == COL_LAST);
   assign frame_end = col_wrap && (row_cnt == ROW_LAST);
   assign emit      = accept && (row_cnt >= ROW_FIRST);
   assign lb0_rd    = lb0[col_cnt];
   assign lb1_rd    = lb1[col_cnt];

   // Both line buffers shift down one row at the current column; contents survive reset.
   always_ff @(posedge clk) begin
      if (accept && !rst) begin
         lb0[col_cnt] <= lb1_rd;
         lb1[col_cnt] <= in_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         col_cnt <= '0;
         row_cnt <= '0;
      end else if (accept) begin
         if (col_wrap) begin
            col_cnt <= '0;
            row_cnt <= frame_end ? '0 : row_cnt + 1'b1;
         end else begin
            col_cnt <= col_cnt + 1'b1;
         end
      end
   end

   // out_word is not cleared by clear; out_valid low already marks it stale.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid  <= 1'b0;
         out_word   <= '0;
         out_first  <= 1'b0;
         out_last   <= 1'b0;
         frame_done <= 1'b0;
      end else if (clear) begin
         out_valid  <= 1'b0;
         out_first  <= 1'b0;
         out_last   <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= accept && frame_end;
         if (emit) begin
            out_valid <= 1'b1;
            out_word  <= {{PAD_W{1'b0}}, in_data, lb1_rd, lb0_rd};
            out_first <= (col_cnt == '0);
            out_last  <= frame_end;
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule
